modal_counter: RTL and testbench

//  Parametrised successor to simple_counter: up/down counter with a run-time

---
 rtl/modal_counter.sv | 150 +++++++++++++++
 tb/tb_modal_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/modal_counter.sv
// modal_counter: up/down counter with run-time terminal value, synchronous
// load and three counting modes (wrap, saturate, one-shot). Emits a
// registered one-cycle pulse on terminal events.
//
// Handshake note: there is no valid/ready pairing here. Every input is
// sampled on each rising clock edge. Outputs are registered and change only
// on that edge.
module modal_counter #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // One-shot FSM state. It is fully visible on busy_o (RUN) and done_o (DONE).
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             sat_q, sat_d;
  state_e           state_q, state_d;
  logic [1:0]       mode_prev_q;
  logic             up_prev_q;

  logic             terminal;
  logic             mode_changed;
  logic             sat_eff;
  logic [WIDTH-1:0] count_step;
  logic [WIDTH-1:0] count_reload;

  // Terminal condition, single-step value and the value reloaded on wrap or start.
  always_comb begin
    terminal     = up_i ? (count_q >= limit_i) : (count_q == '0);
    mode_changed = (mode_i != mode_prev_q);
    // A direction change clears the saturation flag in the same cycle.
    sat_eff      = sat_q & (up_i == up_prev_q);
    count_step   = up_i ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    count_reload = up_i ? '0 : limit_i;
  end

  // Next-state logic. Priority is load > mode change > start > count step.
  always_comb begin
    count_d = count_q;
    pulse_d = 1'b0;
    sat_d   = sat_eff;
    state_d = state_q;

    if (load_i) begin
      count_d = load_value_i;
      sat_d   = 1'b0;
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (mode_changed) begin
      state_d = ST_IDLE;
      sat_d   = 1'b0;
    end else begin
      case (mode_e'(mode_i))
        MODE_WRAP: begin
          if (enable_i) begin
            if (terminal) begin
              count_d = count_reload;
              pulse_d = 1'b1;
            end else begin
              count_d = count_step;
            end
          end
        end
        MODE_SAT: begin
          if (enable_i) begin
            if (terminal) begin
              // Only the first terminal step after saturating produces a pulse.
              pulse_d = ~sat_eff;
              sat_d   = 1'b1;
            end else begin
              count_d = count_step;
            end
          end
        end
        MODE_ONESHOT: begin
          if (start_i && (state_q != ST_RUN)) begin
            state_d = ST_RUN;
            count_d = count_reload;
          end else if ((state_q == ST_RUN) && enable_i) begin
            if (terminal) begin
              state_d = ST_DONE;
              pulse_d = 1'b1;
            end else begin
              count_d = count_step;
            end
          end
        end
        default: begin
          // Hold mode: the count is frozen and no pulse is produced.
        end
      endcase
    end

    // Outside one-shot mode the FSM is parked in IDLE.
    if (mode_i != MODE_ONESHOT) state_d = ST_IDLE;
  end

  // State registers with a synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q     <= RESET_VALUE;
      pulse_q     <= 1'b0;
      sat_q       <= 1'b0;
      state_q     <= ST_IDLE;
      // Track the live inputs during reset so that releasing reset is not
      // seen as a mode or direction change.
      mode_prev_q <= mode_i;
      up_prev_q   <= up_i;
    end else begin
      count_q     <= count_d;
      pulse_q     <= pulse_d;
      sat_q       <= sat_d;
      state_q     <= state_d;
      mode_prev_q <= mode_i;
      up_prev_q   <= up_i;
    end
  end

  assign count_o = count_q;
  assign pulse_o = pulse_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_modal_counter.sv
// Directed bench for modal_counter (WIDTH=4). Every expected value below is
// worked out by hand from the counter's intended behaviour.
module tb_modal_counter;

  localparam int W = 4;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i, enable_i, up_i, load_i, start_i;
  logic [1:0]   mode_i;
  logic [W-1:0] limit_i, load_value_i;
  logic [W-1:0] count_o;
  logic         pulse_o, busy_o, done_o;

  int compared = 0;
  int mismatched = 0;

  // Expected {pulse, count} values for the free-running wrap sequence.
  logic [W:0] exp_q[$];

  modal_counter #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clock_i      (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .up_i         (up_i),
    .mode_i       (mode_i),
    .limit_i      (limit_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .start_i      (start_i),
    .count_o      (count_o),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Driver: advance one clock edge, then settle before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with its expected value.
  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check all four outputs against their expected values.
  task automatic chk(input string tag, input int c, input bit p, input bit b, input bit d);
    cmp({tag, ".count"}, 8'(count_o), 8'(c));
    cmp({tag, ".pulse"}, 8'(pulse_o), 8'(p));
    cmp({tag, ".busy"},  8'(busy_o),  8'(b));
    cmp({tag, ".done"},  8'(done_o),  8'(d));
  endtask

  initial begin
    logic [W:0] e;
    reset_i = 1; enable_i = 0; up_i = 1; mode_i = 2'b00; limit_i = 9;
    load_i = 0; load_value_i = 0; start_i = 0;
    step(); step();
    chk("reset", 0, 0, 0, 0);

    // Wrap up to limit 9. The pulse appears on the cycle the count returns to 0.
    reset_i = 0; enable_i = 1;
    for (int k = 1; k <= 25; k++) exp_q.push_back({(k % 10) == 0, W'(k % 10)});
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      cmp("wrap_up.count", 8'(count_o), 8'(e[W-1:0]));
      cmp("wrap_up.pulse", 8'(pulse_o), 8'(e[W]));
    end

    // Load 12, above the limit. The next up step is terminal.
    load_i = 1; load_value_i = 12; step();
    chk("load12", 12, 0, 0, 0);
    load_i = 0; step();
    chk("over_limit_wrap", 0, 1, 0, 0);

    // Load while enabled, then load at the terminal value. Neither load pulses.
    load_i = 1; load_value_i = 9; step();
    chk("load9", 9, 0, 0, 0);
    load_value_i = 3; step();
    chk("load_at_terminal", 3, 0, 0, 0);
    load_i = 0; step();
    chk("after_load", 4, 0, 0, 0);

    // Wrap down with limit 5 after loading 2: 2,1,0,5(pulse),4,3.
    up_i = 0; limit_i = 5; load_i = 1; load_value_i = 2; step();
    chk("down_load", 2, 0, 0, 0);
    load_i = 0;
    step(); chk("down1", 1, 0, 0, 0);
    step(); chk("down0", 0, 0, 0, 0);
    step(); chk("down_wrap", 5, 1, 0, 0);
    step(); chk("down4", 4, 0, 0, 0);
    step(); chk("down3", 3, 0, 0, 0);

    // Saturate up to 15. The mode-change cycle holds the count.
    mode_i = 2'b01; up_i = 1; limit_i = 15; step();
    chk("sat_modechg", 3, 0, 0, 0);
    for (int k = 4; k <= 15; k++) begin
      step(); chk("sat_climb", k, 0, 0, 0);
    end
    step(); chk("sat_first", 15, 1, 0, 0);
    step(); chk("sat_again1", 15, 0, 0, 0);
    step(); chk("sat_again2", 15, 0, 0, 0);
    // A load clears the saturation flag, so a second single pulse follows.
    load_i = 1; load_value_i = 3; step();
    chk("sat_load", 3, 0, 0, 0);
    load_i = 0;
    for (int k = 4; k <= 15; k++) step();
    chk("sat_reclimb", 15, 0, 0, 0);
    step(); chk("sat_second", 15, 1, 0, 0);
    step(); chk("sat_second_hold", 15, 0, 0, 0);

    // One-shot up to limit 4.
    mode_i = 2'b10; limit_i = 4; step();
    chk("os_modechg", 15, 0, 0, 0);
    step(); chk("os_idle_hold", 15, 0, 0, 0);
    start_i = 1; step();
    chk("os_start", 0, 0, 1, 0);
    start_i = 0;
    for (int k = 1; k <= 4; k++) begin
      step(); chk("os_run", k, 0, 1, 0);
    end
    step(); chk("os_done", 4, 1, 0, 1);
    step(); chk("os_done_hold", 4, 0, 0, 1);
    start_i = 1; step();
    chk("os_restart", 0, 0, 1, 0);
    // A start while running is ignored and the count keeps stepping.
    step(); chk("os_start_in_run", 1, 0, 1, 0);
    start_i = 0; step();
    chk("os_run2", 2, 0, 1, 0);

    // Reset in the middle of a run.
    reset_i = 1; step();
    chk("reset_mid_run", 0, 0, 0, 0);
    reset_i = 0;

    // Hold mode freezes the count.
    mode_i = 2'b11; step();
    chk("hold_modechg", 0, 0, 0, 0);
    load_i = 1; load_value_i = 7; step();
    load_i = 0; step();
    chk("hold_frozen", 7, 0, 0, 0);

    // Wrap up with limit 0: the count stays 0 and pulses on every enabled cycle.
    mode_i = 2'b00; limit_i = 0; load_i = 1; load_value_i = 0; step();
    chk("lim0_load", 0, 0, 0, 0);
    load_i = 0;
    step(); chk("lim0_a", 0, 1, 0, 0);
    step(); chk("lim0_b", 0, 1, 0, 0);
    enable_i = 0; step();
    chk("lim0_disabled", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
